// File: rtl/dec_pkg.sv
// Shared definitions for the N:2^N decoder / one-hot scanner.
//
// Contents:
//   MODE_DIRECT, MODE_UP, MODE_DOWN, MODE_THERM : 2-bit mode encodings
//   onehot_bit(idx, sel) : 1 when output bit idx should be lit for a one-hot of sel
//   therm_bit(idx, sel)  : 1 when output bit idx should be lit for a thermometer of sel
//   pre_width(div)       : prescaler width for a given divide ratio (min 1 bit)
package dec_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_THERM  = 2'b11;

  // The helpers work per output bit so they stay independent of the
  // decoder width; the caller loops over its own output vector.
  function automatic logic onehot_bit(input int unsigned idx, input int unsigned sel);
    return (idx == sel);
  endfunction

  function automatic logic therm_bit(input int unsigned idx, input int unsigned sel);
    return (idx <= sel);
  endfunction

  // A divide ratio of 1 still needs a 1-bit register so the port list and
  // comparisons stay legal; that bit simply never leaves zero.
  function automatic int unsigned pre_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/dec_scan_ctr.sv
// Scan pointer with prescaler and wrap flag.
//
// Ports:
//   clk   in       clock, rising edge
//   rst   in       synchronous active-high reset
//   en    in       enable; low freezes pointer and prescaler
//   mode  in  2    scan direction comes from MODE_UP / MODE_DOWN
//   a     in  N    load value for the pointer
//   ld    in       load pulse: ptr <= a, prescaler cleared (works even with en low)
//   ptr   out N    current scan pointer (registered)
//   wrap  out      one-cycle pulse after the pointer wraps around
module dec_scan_ctr
  import dec_pkg::*;
#(
  parameter int N   = 2,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [N-1:0] a,
  input  logic         ld,
  output logic [N-1:0] ptr,
  output logic         wrap
);

  localparam int unsigned PW = pre_width(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic          wrap_q, wrap_d;
  logic          scan_mode;
  logic          pre_last;

  // Next-state for prescaler, pointer and wrap. A load takes priority over
  // any step that would have happened on the same edge, and never flags a
  // wrap. Outside the scan modes everything holds, so the prescaler phase
  // survives a detour through direct/thermometer mode.
  always_comb begin
    scan_mode = (mode == MODE_UP) || (mode == MODE_DOWN);
    pre_last  = (pre_q == PRE_MAX);
    pre_d     = pre_q;
    ptr_d     = ptr_q;
    wrap_d    = 1'b0;
    if (ld) begin
      ptr_d = a;
      pre_d = '0;
    end else if (en && scan_mode) begin
      if (pre_last) begin
        pre_d = '0;
        if (mode == MODE_UP) begin
          ptr_d  = ptr_q + 1'b1;
          wrap_d = (ptr_q == {N{1'b1}});
        end else begin
          ptr_d  = ptr_q - 1'b1;
          wrap_d = (ptr_q == '0);
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr  = ptr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/dec_n_scan.sv
// Registered N:2^N decoder with enable and a built-in one-hot scanner.
//
// Ports:
//   clk   in         clock, rising edge
//   rst   in         synchronous active-high reset
//   en    in         enable; low forces d to zero next cycle
//   mode  in  2      00 direct, 01 scan up, 10 scan down, 11 thermometer
//   a     in  N      address (direct/thermometer) or pointer load value
//   ld    in         load pulse for the scan pointer
//   d     out 2**N   registered decoded output
//   ptr   out N      current scan pointer
//   wrap  out        one-cycle pulse when the scan pointer wraps
module dec_n_scan
  import dec_pkg::*;
#(
  parameter int N   = 2,
  parameter int DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      a,
  input  logic              ld,
  output logic [(1<<N)-1:0] d,
  output logic [N-1:0]      ptr,
  output logic              wrap
);

  localparam int OUT = 1 << N;

  logic [OUT-1:0] d_q, d_d;
  logic [N-1:0]   ptr_cur;

  dec_scan_ctr #(
    .N   (N),
    .DIV (DIV)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .a    (a),
    .ld   (ld),
    .ptr  (ptr_cur),
    .wrap (wrap)
  );

  // Decode mux. Scan modes light the pointer value as it stands before this
  // edge, so the displayed position lags the pointer update by design.
  always_comb begin
    d_d = '0;
    if (en) begin
      for (int i = 0; i < OUT; i++) begin
        case (mode)
          MODE_DIRECT: d_d[i] = onehot_bit(i, 32'(a));
          MODE_THERM:  d_d[i] = therm_bit(i, 32'(a));
          default:     d_d[i] = onehot_bit(i, 32'(ptr_cur));
        endcase
      end
    end
  end

  // Output register keeps the selects glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

  assign d   = d_q;
  assign ptr = ptr_cur;

endmodule

// File: tb/tb_dec_n_scan.sv
// Self-checking bench for dec_n_scan: a DIV=3 and a DIV=1 instance share
// inputs; every cycle both are compared against an arithmetic reference
// model, and hand-written vector tables check the documented sequences.
module tb_dec_n_scan;

  localparam int N   = 2;
  localparam int OUT = 4;

  logic           clk = 1'b0;
  logic           rst, en, ld;
  logic [1:0]     mode;
  logic [N-1:0]   a;
  logic [OUT-1:0] d3, d1;
  logic [N-1:0]   ptr3, ptr1;
  logic           wrap3, wrap1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dec_n_scan #(.N(N), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .ld(ld),
    .d(d3), .ptr(ptr3), .wrap(wrap3)
  );

  dec_n_scan #(.N(N), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .ld(ld),
    .d(d1), .ptr(ptr1), .wrap(wrap1)
  );

  // Reference model: pointer as an integer, phase counts enabled scan cycles.
  typedef struct {
    logic [OUT-1:0] d;
    int             ptr;
    int             phase;
    logic           wrap;
  } model_t;

  model_t m3 = '{d: '0, ptr: 0, phase: 0, wrap: 1'b0};
  model_t m1 = '{d: '0, ptr: 0, phase: 0, wrap: 1'b0};

  function automatic model_t model_step(input model_t s, input logic r, input logic e,
                                        input logic [1:0] m, input logic [1:0] aa,
                                        input logic l, input int div);
    model_t n = s;
    int ai = int'(aa);
    if (r) begin
      n.d = '0; n.ptr = 0; n.phase = 0; n.wrap = 1'b0;
      return n;
    end
    n.wrap = 1'b0;
    if (!e)         n.d = '0;
    else if (m == 0) n.d = OUT'(1 << ai);
    else if (m == 3) n.d = OUT'((2 << ai) - 1);
    else             n.d = OUT'(1 << s.ptr);
    if (l) begin
      n.ptr = ai;
      n.phase = 0;
    end else if (e && (m == 1 || m == 2)) begin
      n.phase = s.phase + 1;
      if (n.phase == div) begin
        n.phase = 0;
        if (m == 1) begin
          n.ptr  = (s.ptr + 1) % OUT;
          n.wrap = (n.ptr == 0);
        end else begin
          n.ptr  = (s.ptr + OUT - 1) % OUT;
          n.wrap = (n.ptr == OUT - 1);
        end
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string name,
                             input logic [OUT-1:0] d_act, input logic [N-1:0] p_act, input logic w_act,
                             input logic [OUT-1:0] d_exp, input logic [N-1:0] p_exp, input logic w_exp);
    total++;
    if (d_act !== d_exp || p_act !== p_exp || w_act !== w_exp) begin
      bad++;
      $display("[TB] FAIL %s: got d=%b ptr=%0d wrap=%b, expected d=%b ptr=%0d wrap=%b",
               name, d_act, p_act, w_act, d_exp, p_exp, w_exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then check both DUTs
  // against the model a little after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic [1:0] aa, input logic l);
    rst = r; en = e; mode = m; a = aa; ld = l;
    @(posedge clk);
    #1;
    m3 = model_step(m3, r, e, m, aa, l, 3);
    m1 = model_step(m1, r, e, m, aa, l, 1);
    checkOutput("model_div3", d3, ptr3, wrap3, m3.d, N'(m3.ptr), m3.wrap);
    checkOutput("model_div1", d1, ptr1, wrap1, m1.d, N'(m1.ptr), m1.wrap);
  endtask

  typedef struct {
    logic           rst, en;
    logic [1:0]     mode, a;
    logic           ld;
    logic [OUT-1:0] d;
    logic [N-1:0]   ptr;
    logic           wrap;
  } vec_t;

  vec_t vecs3[$];
  vec_t vecs1[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                              input logic [1:0] aa, input logic l,
                              input logic [OUT-1:0] dx, input logic [N-1:0] px, input logic wx);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.a = aa; v.ld = l;
    v.d = dx; v.ptr = px; v.wrap = wx;
    return v;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; a = 2'd3; ld = 1'b0;

    // Expected values for the DIV=3 instance.
    vecs3.push_back(mk(1,1,0,3,0, 4'b0000,0,0));   // reset
    vecs3.push_back(mk(1,1,0,3,0, 4'b0000,0,0));
    vecs3.push_back(mk(0,1,0,0,0, 4'b0001,0,0));   // direct
    vecs3.push_back(mk(0,1,0,1,0, 4'b0010,0,0));
    vecs3.push_back(mk(0,1,0,2,0, 4'b0100,0,0));
    vecs3.push_back(mk(0,1,0,3,0, 4'b1000,0,0));
    vecs3.push_back(mk(0,0,0,3,0, 4'b0000,0,0));   // disabled
    vecs3.push_back(mk(0,1,3,0,0, 4'b0001,0,0));   // thermometer
    vecs3.push_back(mk(0,1,3,1,0, 4'b0011,0,0));
    vecs3.push_back(mk(0,1,3,2,0, 4'b0111,0,0));
    vecs3.push_back(mk(0,1,3,3,0, 4'b1111,0,0));
    vecs3.push_back(mk(0,0,0,2,1, 4'b0000,2,0));   // load 2 while disabled
    vecs3.push_back(mk(0,1,1,0,0, 4'b0100,2,0));   // scan up, 3 cycles per step
    vecs3.push_back(mk(0,1,1,0,0, 4'b0100,2,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b0100,3,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b1000,3,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b1000,3,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b1000,0,1));   // wrap 3->0
    vecs3.push_back(mk(0,1,1,0,0, 4'b0001,0,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b0001,0,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b0001,1,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b0010,1,0));   // phase 1
    vecs3.push_back(mk(0,0,1,0,0, 4'b0000,1,0));   // frozen
    vecs3.push_back(mk(0,0,1,0,0, 4'b0000,1,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b0010,1,0));   // resumes at phase 2
    vecs3.push_back(mk(0,1,1,0,0, 4'b0010,2,0));
    vecs3.push_back(mk(0,1,1,3,1, 4'b0100,3,0));   // load 3
    vecs3.push_back(mk(0,1,1,0,0, 4'b1000,3,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b1000,3,0));
    vecs3.push_back(mk(0,1,1,1,1, 4'b1000,1,0));   // load beats wrapping step
    vecs3.push_back(mk(0,1,1,0,0, 4'b0010,1,0));
    vecs3.push_back(mk(1,1,1,0,0, 4'b0000,0,0));   // reset mid-scan
    vecs3.push_back(mk(0,1,1,0,0, 4'b0001,0,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b0001,0,0));
    vecs3.push_back(mk(0,1,1,0,0, 4'b0001,1,0));   // restart with prescaler 0

    // DIV=1 instance scanning down from 1.
    vecs1.push_back(mk(0,0,0,1,1, 4'b0000,1,0));
    vecs1.push_back(mk(0,1,2,0,0, 4'b0010,0,0));
    vecs1.push_back(mk(0,1,2,0,0, 4'b0001,3,1));   // wrap 0->3
    vecs1.push_back(mk(0,1,2,0,0, 4'b1000,2,0));
    vecs1.push_back(mk(0,1,2,0,0, 4'b0100,1,0));

    foreach (vecs3[i]) begin
      applyStimulus(vecs3[i].rst, vecs3[i].en, vecs3[i].mode, vecs3[i].a, vecs3[i].ld);
      checkOutput($sformatf("vec3_%0d", i), d3, ptr3, wrap3,
                  vecs3[i].d, vecs3[i].ptr, vecs3[i].wrap);
    end

    foreach (vecs1[i]) begin
      applyStimulus(vecs1[i].rst, vecs1[i].en, vecs1[i].mode, vecs1[i].a, vecs1[i].ld);
      checkOutput($sformatf("vec1_%0d", i), d1, ptr1, wrap1,
                  vecs1[i].d, vecs1[i].ptr, vecs1[i].wrap);
    end

    // Randomized traffic; the model check inside applyStimulus does the work.
    for (int k = 0; k < 500; k++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 4) != 0,
                    2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)),
                    $urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
